// File: rtl/operand_fetch.sv
// operand_fetch: one-stage operand fetch with a scoreboard that tracks pending register writes.
// Define OPERAND_FETCH_BYPASS_EN to forward same-cycle writeback data instead of stalling for it.
module operand_fetch #(
    parameter int addr_size = 5,
    parameter int cell_size = 32,
    parameter int op_size   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [addr_size-1:0] in_rs1,
    input  logic [addr_size-1:0] in_rs2,
    input  logic [addr_size-1:0] in_rd,
    input  logic                 in_rd_we,
    input  logic [op_size-1:0]   in_op,
    output logic [addr_size-1:0] rf_r1,
    output logic [addr_size-1:0] rf_r2,
    input  logic [cell_size-1:0] rf_r1data,
    input  logic [cell_size-1:0] rf_r2data,
    input  logic                 wb_valid,
    input  logic [addr_size-1:0] wb_rd,
    input  logic [cell_size-1:0] wb_data,
    output logic                 rf_we,
    output logic [addr_size-1:0] rf_rd,
    output logic [cell_size-1:0] rf_rddata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [op_size-1:0]   out_op,
    output logic [addr_size-1:0] out_rd,
    output logic                 out_rd_we,
    output logic [cell_size-1:0] out_rs1data,
    output logic [cell_size-1:0] out_rs2data
);
    localparam int nregs = 1 << addr_size;

    logic [nregs-1:0]     pending;
    logic                 s1_valid;
    logic [addr_size-1:0] s1_rs1, s1_rs2, s1_rd;
    logic                 s1_rd_we;
    logic [op_size-1:0]   s1_op;
    logic                 wb_hit1, wb_hit2, haz1, haz2, transfer;
    logic [nregs-1:0]     set_mask, clr_mask;

    assign wb_hit1 = wb_valid && wb_rd == in_rs1;
    assign wb_hit2 = wb_valid && wb_rd == in_rs2;
`ifdef OPERAND_FETCH_BYPASS_EN
    assign haz1 = in_rs1 != '0 && pending[in_rs1] && !wb_hit1;
    assign haz2 = in_rs2 != '0 && pending[in_rs2] && !wb_hit2;
`else
    // the register file cannot return same-cycle writeback data, so wait a cycle for it
    assign haz1 = in_rs1 != '0 && (pending[in_rs1] || wb_hit1);
    assign haz2 = in_rs2 != '0 && (pending[in_rs2] || wb_hit2);
`endif
    assign in_ready  = (!s1_valid || out_ready) && !haz1 && !haz2;
    assign transfer  = in_valid && in_ready;
    assign rf_r1     = transfer ? in_rs1 : s1_rs1;
    assign rf_r2     = transfer ? in_rs2 : s1_rs2;
    assign rf_we     = wb_valid && wb_rd != '0;
    assign rf_rd     = wb_rd;
    assign rf_rddata = wb_data;
    assign out_valid = s1_valid;
    assign out_op    = s1_op;
    assign out_rd    = s1_rd;
    assign out_rd_we = s1_rd_we;
    assign set_mask  = (transfer && in_rd_we && in_rd != '0) ? nregs'(1) << in_rd : '0;
    assign clr_mask  = wb_valid ? nregs'(1) << wb_rd : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= '0;
            s1_valid <= 1'b0;
            s1_rs1   <= '0;
            s1_rs2   <= '0;
            s1_rd    <= '0;
            s1_rd_we <= 1'b0;
            s1_op    <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
            if (transfer) begin
                s1_valid <= 1'b1;
                s1_rs1   <= in_rs1;
                s1_rs2   <= in_rs2;
                s1_rd    <= in_rd;
                s1_rd_we <= in_rd_we;
                s1_op    <= in_op;
            end else if (out_ready) begin
                s1_valid <= 1'b0;
            end
        end
    end

`ifdef OPERAND_FETCH_BYPASS_EN
    logic                 byp1_f, byp2_f;
    logic [cell_size-1:0] byp1, byp2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byp1_f <= 1'b0;
            byp2_f <= 1'b0;
            byp1   <= '0;
            byp2   <= '0;
        end else if (transfer) begin
            byp1_f <= wb_hit1 && in_rs1 != '0;
            byp2_f <= wb_hit2 && in_rs2 != '0;
            if (wb_hit1) byp1 <= wb_data;
            if (wb_hit2) byp2 <= wb_data;
        end
    end

    assign out_rs1data = s1_rs1 == '0 ? '0 : byp1_f ? byp1 : rf_r1data;
    assign out_rs2data = s1_rs2 == '0 ? '0 : byp2_f ? byp2 : rf_r2data;
`else
    assign out_rs1data = s1_rs1 == '0 ? '0 : rf_r1data;
    assign out_rs2data = s1_rs2 == '0 ? '0 : rf_r2data;
`endif
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed checks of operand_fetch against a registered-read register file model.
module tb_operand_fetch;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic        in_rd_we = 1'b0;
    logic [15:0] in_op = '0;
    logic [4:0]  rf_r1, rf_r2;
    logic [31:0] rf_r1data = '0, rf_r2data = '0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_rddata;
    logic        out_valid, out_ready = 1'b0;
    logic [15:0] out_op;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [31:0] out_rs1data, out_rs2data;
    logic        rf_init = 1'b0;
    logic [31:0] regs [32];
    int checks = 0;
    int errors = 0;

    operand_fetch dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we), .in_op(in_op),
        .rf_r1(rf_r1), .rf_r2(rf_r2), .rf_r1data(rf_r1data), .rf_r2data(rf_r2data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_rddata(rf_rddata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rd(out_rd), .out_rd_we(out_rd_we),
        .out_rs1data(out_rs1data), .out_rs2data(out_rs2data)
    );

    always #5 clk = ~clk;

    // register file: registered reads return the pre-write value; r0 holds garbage on purpose
    always @(posedge clk) begin
        if (!rf_init) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            regs[0] <= 32'hDEAD_BEEF;
            regs[3] <= 32'd7;
            regs[4] <= 32'd9;
        end else begin
            rf_r1data <= regs[rf_r1];
            rf_r2data <= regs[rf_r2];
            if (rf_we) regs[rf_rd] <= rf_rddata;
        end
    end

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_op !== 16'h0) begin errors++; $display("FAIL reset_out_op: got %h want 0000", out_op); end
        checks++; if (out_rd !== 5'd0) begin errors++; $display("FAIL reset_out_rd: got %0d want 0", out_rd); end
        checks++; if (out_rd_we !== 1'b0) begin errors++; $display("FAIL reset_out_rd_we: got %b want 0", out_rd_we); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        rf_init = 1'b1;
    endtask

    task automatic test_basic;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        in_rs1 = 5'd3; in_rs2 = 5'd4; in_rd = 5'd5; in_rd_we = 1'b1; in_op = 16'h00A1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
        checks++; if (rf_r1 !== 5'd3) begin errors++; $display("FAIL basic_rf_r1: got %0d want 3", rf_r1); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b want 1", out_valid); end
        checks++; if (out_rs1data !== 32'd7) begin errors++; $display("FAIL basic_rs1data: got %h want 7", out_rs1data); end
        checks++; if (out_rs2data !== 32'd9) begin errors++; $display("FAIL basic_rs2data: got %h want 9", out_rs2data); end
        checks++; if (out_rd !== 5'd5) begin errors++; $display("FAIL basic_out_rd: got %0d want 5", out_rd); end
        checks++; if (out_rd_we !== 1'b1) begin errors++; $display("FAIL basic_out_rd_we: got %b want 1", out_rd_we); end
        checks++; if (out_op !== 16'h00A1) begin errors++; $display("FAIL basic_out_op: got %h want 00a1", out_op); end
    endtask

    task automatic test_hazard;
        @(negedge clk);
        in_rs1 = 5'd5; in_rs2 = 5'd0; in_rd = 5'd6; in_rd_we = 1'b0; in_op = 16'h00B2;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_stall: got %b want 0", in_ready); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_stall2: got %b want 0", in_ready); end
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h55;
        #1;
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL hazard_rf_we: got %b want 1", rf_we); end
        checks++; if (rf_rddata !== 32'h55) begin errors++; $display("FAIL hazard_rf_rddata: got %h want 55", rf_rddata); end
`ifdef OPERAND_FETCH_BYPASS_EN
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hazard_bypass_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
`else
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_wb_stall: got %b want 0", in_ready); end
        @(negedge clk);
        wb_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hazard_release: got %b want 1", in_ready); end
        @(posedge clk); #1;
`endif
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hazard_out_valid: got %b want 1", out_valid); end
        checks++; if (out_rs1data !== 32'h55) begin errors++; $display("FAIL hazard_rs1data: got %h want 55", out_rs1data); end
        checks++; if (out_op !== 16'h00B2) begin errors++; $display("FAIL hazard_out_op: got %h want 00b2", out_op); end
        @(negedge clk);
        wb_valid = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        in_rs1 = 5'd3; in_rs2 = 5'd4; in_rd = 5'd0; in_rd_we = 1'b0; in_op = 16'h00C3;
        @(posedge clk); #1;
        checks++; if (out_op !== 16'h00C3) begin errors++; $display("FAIL bp_load_op: got %h want 00c3", out_op); end
        @(negedge clk);
        out_ready = 1'b0; in_rs1 = 5'd4; in_rs2 = 5'd3; in_op = 16'h00D4;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        checks++; if (rf_r1 !== 5'd3) begin errors++; $display("FAIL bp_reread_r1: got %0d want 3", rf_r1); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", c, out_valid); end
            checks++; if (out_op !== 16'h00C3) begin errors++; $display("FAIL bp_hold_op[%0d]: got %h want 00c3", c, out_op); end
            checks++; if (out_rs1data !== 32'd7) begin errors++; $display("FAIL bp_hold_rs1[%0d]: got %h want 7", c, out_rs1data); end
            checks++; if (out_rs2data !== 32'd9) begin errors++; $display("FAIL bp_hold_rs2[%0d]: got %h want 9", c, out_rs2data); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_resume_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_op !== 16'h00D4) begin errors++; $display("FAIL b2b_op1: got %h want 00d4", out_op); end
        checks++; if (out_rs1data !== 32'd9) begin errors++; $display("FAIL b2b_rs1_1: got %h want 9", out_rs1data); end
        checks++; if (out_rs2data !== 32'd7) begin errors++; $display("FAIL b2b_rs2_1: got %h want 7", out_rs2data); end
        @(negedge clk);
        in_rs1 = 5'd0; in_rs2 = 5'd4; in_op = 16'h00E5;
        @(posedge clk); #1;
        checks++; if (out_op !== 16'h00E5) begin errors++; $display("FAIL b2b_op2: got %h want 00e5", out_op); end
        checks++; if (out_rs1data !== 32'd0) begin errors++; $display("FAIL b2b_rs1_2: got %h want 0", out_rs1data); end
        checks++; if (out_rs2data !== 32'd9) begin errors++; $display("FAIL b2b_rs2_2: got %h want 9", out_rs2data); end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_zero;
        @(negedge clk);
        in_valid = 1'b1; in_rs1 = 5'd0; in_rs2 = 5'd3; in_rd = 5'd0; in_rd_we = 1'b1; in_op = 16'h00F6;
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL zero_rf_we: got %b want 0", rf_we); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_rs1data !== 32'd0) begin errors++; $display("FAIL zero_rs1data: got %h want 0", out_rs1data); end
        checks++; if (out_rs2data !== 32'd7) begin errors++; $display("FAIL zero_rs2data: got %h want 7", out_rs2data); end
        checks++; if (out_rd_we !== 1'b1) begin errors++; $display("FAIL zero_rd_we: got %b want 1", out_rd_we); end
        @(negedge clk);
        in_valid = 1'b0; wb_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        in_valid = 1'b1; in_rs1 = 5'd3; in_rs2 = 5'd4; in_rd = 5'd7; in_rd_we = 1'b1; in_op = 16'h0077;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_loaded: got %b want 1", out_valid); end
        @(negedge clk);
        in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'h22;
        #1 reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
        checks++; if (out_op !== 16'h0) begin errors++; $display("FAIL rmid_out_op: got %h want 0000", out_op); end
        checks++; if (out_rd !== 5'd0) begin errors++; $display("FAIL rmid_out_rd: got %0d want 0", out_rd); end
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL rmid_rf_we: got %b want 1", rf_we); end
        @(negedge clk);
        reset_n = 1'b1; wb_valid = 1'b0;
        in_valid = 1'b1; in_rs1 = 5'd7; in_rs2 = 5'd2; in_rd = 5'd0; in_rd_we = 1'b0; in_op = 16'h0088;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_no_stall: got %b want 1", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_accept: got %b want 1", out_valid); end
        checks++; if (out_rs1data !== 32'd0) begin errors++; $display("FAIL rmid_rs1data: got %h want 0", out_rs1data); end
        checks++; if (out_rs2data !== 32'h22) begin errors++; $display("FAIL rmid_rs2data: got %h want 22", out_rs2data); end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_hazard;
        test_back_to_back;
        test_zero;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter addr_size, default 5, SHALL be the register index width (2**addr_size registers).
REQ-002 Parameter cell_size, default 32, SHALL be the register data width.
REQ-003 Parameter op_size, default 16, SHALL be the width of the opaque payload carried from decode to execute.
REQ-004 clk  in  1  sole clock, all state on its rising edge.
REQ-005 reset_n  in  1  reset, asynchronous and active-low.
REQ-006 in_valid/in_ready  in/out  1/1  decode-side handshake; transfer when both high.
REQ-007 in_rs1, in_rs2, in_rd  in  addr_size each  source and destination indices.
REQ-008 in_rd_we  in  1  instruction writes in_rd.
REQ-009 in_op  in  op_size  payload.
REQ-010 rf_r1, rf_r2  out  addr_size each  register file read addresses.
REQ-011 rf_r1data, rf_r2data  in  cell_size each  register file read data, registered, one cycle after address.
REQ-012 wb_valid, wb_rd, wb_data  in  1/addr_size/cell_size  writeback request.
REQ-013 rf_we, rf_rd, rf_rddata  out  1/addr_size/cell_size  register file write port.
REQ-014 out_valid/out_ready  out/in  1/1  execute-side handshake.
REQ-015 out_op, out_rd, out_rd_we, out_rs1data, out_rs2data  out  payload, destination, and operands to execute.

Function
REQ-016 Single stage S1 (s1_valid, rs1, rs2, rd, rd_we, op); out_valid SHALL equal s1_valid.
REQ-017 in_ready SHALL be high iff (!s1_valid || out_ready) and no hazard per REQ-020.
REQ-018 rf_r1/rf_r2 SHALL be in_rs1/in_rs2 in cycles where a transfer occurs, else s1_rs1/s1_rs2 (re-read holds operands stable under backpressure).
REQ-019 Scoreboard: one pending bit per register; bit rd SHALL set on transfer with in_rd_we=1 and in_rd!=0, clear when wb_valid with wb_rd=rd; simultaneous set and clear of the same bit: set wins.
REQ-020 Hazard: in_rs1 or in_rs2 (non-zero) has its pending bit set and is not being cleared by wb this cycle.
REQ-021 Latency: transfer in cycle N -> out_valid and valid operands in cycle N+1.
REQ-022 Operand value SHALL be 0 for index 0; else the bypass register if its flag is set; else rf_rNdata.
REQ-023 Register 0 SHALL never be written: rf_we = wb_valid && wb_rd!=0; rf_rd=wb_rd, rf_rddata=wb_data combinationally.
REQ-024 S1 SHALL hold all fields while out_valid && !out_ready; transfer with out_ready in the same cycle SHALL replace S1 (full throughput, 1 instr/cycle).
REQ-025 S1 SHALL clear valid when out_ready and no transfer.
REQ-026 wb_valid without matching pending bit SHALL still write the regfile; the scoreboard is unchanged.

Reset
REQ-027 On reset_n low, immediately: s1_valid=0, all S1 fields=0, scoreboard=0, bypass flags=0; thus out_valid=0, out_rd=0, out_rd_we=0, out_op=0.
REQ-028 Reset mid-operation SHALL discard S1 and all pending marks; rf_we follows wb_valid only (combinational).

Configuration
REQ-029 Macro OPERAND_FETCH_BYPASS_EN defined: on transfer, if wb_valid && wb_rd!=0 && wb_rd==in_rsN, wb_data SHALL be captured into bypass register N with flag set; flags clear on the next transfer without a match.
REQ-030 Macro undefined: no bypass registers; a source matching same-cycle wb_rd SHALL count as hazard (in_ready=0), costing one cycle.

Verification
REQ-031 After reset, rf holds r3=7, r4=9: transfer rs1=3, rs2=4, rd=5, we=1, op=0x00A1 -> next cycle out_valid=1, rs1data=7, rs2data=9, out_rd=5; pending[5]=1.
REQ-032 Then transfer rs1=5 while pending[5] -> in_ready=0 until wb_valid wb_rd=5 wb_data=0x55; with BYPASS_EN accepted that cycle and out_rs1data=0x55 next cycle; without, accepted one cycle later with 0x55.
REQ-033 out_ready=0 for 3 cycles with S1 valid -> out fields and operands unchanged, in_ready=0; out_ready=1 -> back-to-back transfers continue at 1/cycle.
REQ-034 rs1=0, wb_valid wb_rd=0 wb_data=0xFFFF -> rf_we=0, out_rs1data=0, no pending set for in_rd=0.
REQ-035 reset_n pulsed low with S1 valid and pending[7]=1 -> out_valid=0 immediately; after release rs1=7 accepted without stall.
